// File: rtl/y86_dmem_ctrl.sv
// Clocked Y86-64 data memory: byte-addressed, little-endian, 8-byte accesses behind a valid/ready port.
// Optional alignment trapping is enabled by defining DMEM_ALIGN_CHECK_EN.
module y86_dmem_ctrl #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | access latched, latency down-counter running
  // RESP  | response fields valid for one cycle
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          wr_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [7:0]    mem [DEPTH];
  logic          accept;
  logic          commit;
  logic          acc_err;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;
  logic [64:0]   last_byte;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;
  assign commit     = (state == S_WAIT) && (cnt == 4'd0);
  assign base       = addr_q[AW-1:0];

  // 65-bit sum so addresses near 2^64 cannot wrap back into range
  assign last_byte = {1'b0, addr_q} + 65'd7;

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (last_byte > 65'(DEPTH - 1)) || (addr_q[2:0] != 3'd0);
`else
  assign acc_err = (last_byte > 65'(DEPTH - 1));
`endif

  // WAIT spans LATENCY cycles so the response lands LATENCY edges after accept
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        resp_error <= acc_err;
        resp_rdata <= (acc_err || wr_q) ? 64'd0 : rd_word;
      end
    end
  end

  // Contents are deliberately not reset; async reset forces IDLE, which blocks any commit
  always_ff @(posedge clk) begin
    if (commit && wr_q && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
